// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: registered fixed-priority arbiter for LLC input channels.
// Ages req/dma losses so they get boosted ahead of the fixed order.
module llc_input_arbiter #(
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W = 4,
  parameter int CNT_STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arb_en,
  input  logic                  rst_tb_valid,
  input  logic                  rsp_valid,
  input  logic                  req_valid,
  input  logic                  dma_valid,
  input  logic                  recall_pending,
  input  logic                  req_stall,
  input  logic                  dma_pending,
  input  logic                  gnt_ready,
  output logic                  gnt_valid,
  output logic [3:0]            gnt_onehot,
  output logic [1:0]            gnt_id,
  output logic                  gnt_boost,
  output logic                  pop_rst_tb,
  output logic                  pop_rsp,
  output logic                  pop_req,
  output logic                  pop_dma,
  output logic [CNT_STAT_W-1:0] gnt_count
);

  localparam logic ARB  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] A_ONE = CNT_W'(1);
  localparam logic [CNT_STAT_W-1:0] C_ONE = CNT_STAT_W'(1);

  logic             state;
  logic [CNT_W-1:0] age_req;
  logic [CNT_W-1:0] age_dma;

  logic e_rst, e_rsp, e_req, e_dma;
  logic b_req, b_dma;
  logic [3:0] win_oh;
  logic [1:0] win_id;
  logic       win_boost;
  logic       take;
  logic       done;

  assign e_rst = rst_tb_valid & ~dma_pending & ~recall_pending;
  assign e_rsp = rsp_valid;
  assign e_req = req_valid & ~req_stall & ~recall_pending;
  assign e_dma = dma_valid & ~req_stall & ~recall_pending;

  assign b_req = e_req & (age_req == LIM);
  assign b_dma = e_dma & (age_dma == LIM);

  assign gnt_valid = (state == HOLD);
  assign done      = gnt_valid & gnt_ready;
  assign take      = (state == ARB) & arb_en
                   & (e_rst | e_rsp | e_req | e_dma);

  assign pop_rst_tb = done & gnt_onehot[0];
  assign pop_rsp    = done & gnt_onehot[1];
  assign pop_req    = done & gnt_onehot[2];
  assign pop_dma    = done & gnt_onehot[3];

  // Pick the first true term: boosts first, then fixed order.
  always_comb begin
    win_oh    = 4'b0000;
    win_id    = 2'd0;
    win_boost = 1'b0;
    priority case (1'b1)
      b_req: begin win_oh = 4'b0100; win_id = 2'd2; win_boost = 1'b1; end
      b_dma: begin win_oh = 4'b1000; win_id = 2'd3; win_boost = 1'b1; end
      e_rst: begin win_oh = 4'b0001; win_id = 2'd0; end
      e_rsp: begin win_oh = 4'b0010; win_id = 2'd1; end
      e_req: begin win_oh = 4'b0100; win_id = 2'd2; end
      e_dma: begin win_oh = 4'b1000; win_id = 2'd3; end
      default: begin win_oh = 4'b0000; win_id = 2'd0; end
    endcase
  end

  // ARB/HOLD sequencing: grab on take, release on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
    end else if (take) begin
      state <= HOLD;
    end else if (done) begin
      state <= ARB;
    end
  end

  // Latch the winner; fields stay frozen for the whole hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_onehot <= 4'b0000;
      gnt_id     <= 2'd0;
      gnt_boost  <= 1'b0;
    end else if (take) begin
      gnt_onehot <= win_oh;
      gnt_id     <= win_id;
      gnt_boost  <= win_boost;
    end
  end

  // Aging: clear on win, count a loss only if eligible, saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_req <= '0;
      age_dma <= '0;
    end else if (take) begin
      if (win_oh[2])
        age_req <= '0;
      else if (e_req && age_req != LIM)
        age_req <= age_req + A_ONE;
      if (win_oh[3])
        age_dma <= '0;
      else if (e_dma && age_dma != LIM)
        age_dma <= age_dma + A_ONE;
    end
  end

  // Accepted-grant statistics, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_count <= '0;
    end else if (done) begin
      gnt_count <= gnt_count + C_ONE;
    end
  end

endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb_llc_input_arbiter: directed + random checks against a queue model.
// Channels are entry counters; a pop removes one entry.
module tb_llc_input_arbiter;

  localparam int LIM = 3;

  logic        clk;
  logic        rst;
  logic        arb_en;
  logic        rst_tb_valid, rsp_valid, req_valid, dma_valid;
  logic        recall_pending, req_stall, dma_pending;
  logic        gnt_ready;
  logic        gnt_valid;
  logic [3:0]  gnt_onehot;
  logic [1:0]  gnt_id;
  logic        gnt_boost;
  logic        pop_rst_tb, pop_rsp, pop_req, pop_dma;
  logic [15:0] gnt_count;

  llc_input_arbiter #(
    .STARVE_LIMIT(LIM),
    .CNT_W(4),
    .CNT_STAT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb_en(arb_en),
    .rst_tb_valid(rst_tb_valid),
    .rsp_valid(rsp_valid),
    .req_valid(req_valid),
    .dma_valid(dma_valid),
    .recall_pending(recall_pending),
    .req_stall(req_stall),
    .dma_pending(dma_pending),
    .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid),
    .gnt_onehot(gnt_onehot),
    .gnt_id(gnt_id),
    .gnt_boost(gnt_boost),
    .pop_rst_tb(pop_rst_tb),
    .pop_rsp(pop_rsp),
    .pop_req(pop_req),
    .pop_dma(pop_dma),
    .gnt_count(gnt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // model state
  int qcnt[4];
  int popn[4];
  int age[4];
  bit m_hold;
  int m_id;
  bit m_boost;
  int m_count;
  int last_ids[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_id = 0;
    m_boost = 0;
    m_count = 0;
    for (int i = 0; i < 4; i++) age[i] = 0;
  endtask

  task automatic drive_valids();
    rst_tb_valid = (qcnt[0] > 0);
    rsp_valid    = (qcnt[1] > 0);
    req_valid    = (qcnt[2] > 0);
    dma_valid    = (qcnt[3] > 0);
  endtask

  // One clock: settle, check outputs, clock, advance the model.
  task automatic cycle();
    bit v[4];
    bit e[4];
    int cand[$];
    bit candb[$];
    logic [3:0] pops;
    logic [3:0] exp_pops;
    int w;
    drive_valids();
    for (int i = 0; i < 4; i++) v[i] = (qcnt[i] > 0);
    e[0] = v[0] && !dma_pending && !recall_pending;
    e[1] = v[1];
    e[2] = v[2] && !req_stall && !recall_pending;
    e[3] = v[3] && !req_stall && !recall_pending;
    #4;
    chk("gnt_valid", 32'(gnt_valid), 32'(m_hold));
    if (m_hold) begin
      chk("gnt_onehot", 32'(gnt_onehot), 32'(1 << m_id));
      chk("gnt_id", 32'(gnt_id), 32'(m_id));
      chk("gnt_boost", 32'(gnt_boost), 32'(m_boost));
      tests++;
      assert (v[m_id]) else begin
        fails++;
        $error("FAIL protocol observed=valid_drop expected=%0d", m_id);
      end
    end
    pops = {pop_dma, pop_req, pop_rsp, pop_rst_tb};
    exp_pops = (m_hold && gnt_ready) ? 4'(1 << m_id) : 4'b0000;
    chk("pops", 32'(pops), 32'(exp_pops));
    chk("gnt_count", 32'(gnt_count), 32'(m_count));
    for (int i = 0; i < 4; i++) if (pops[i]) popn[i]++;
    @(posedge clk);
    if (m_hold && gnt_ready) begin
      m_count = (m_count + 1) % 65536;
      qcnt[m_id]--;
      last_ids.push_back(m_id);
      m_hold = 0;
    end else if (!m_hold && arb_en) begin
      if (e[2] && age[2] == LIM) begin cand.push_back(2); candb.push_back(1); end
      if (e[3] && age[3] == LIM) begin cand.push_back(3); candb.push_back(1); end
      for (int i = 0; i < 4; i++)
        if (e[i]) begin cand.push_back(i); candb.push_back(0); end
      if (cand.size() > 0) begin
        w = cand[0];
        m_id = w;
        m_boost = candb[0];
        m_hold = 1;
        for (int c = 2; c < 4; c++) begin
          if (w == c) age[c] = 0;
          else if (e[c] && age[c] < LIM) age[c]++;
        end
      end
    end
    #1;
  endtask

  task automatic quiet();
    arb_en = 1; recall_pending = 0; req_stall = 0;
    dma_pending = 0; gnt_ready = 1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin qcnt[i] = 0; popn[i] = 0; end
    last_ids.delete();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_all();
    model_reset();
    quiet();
    drive_valids();
    rst = 0;
    #2;
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    chk("reset_onehot", 32'(gnt_onehot), 32'd0);
    chk("reset_count", 32'(gnt_count), 32'd0);
    @(posedge clk); #1;
    rst = 1;

    // all four valid, ready tied high
    clear_all();
    for (int i = 0; i < 4; i++) qcnt[i] = 1;
    repeat (8) cycle();
    chk("order_n", 32'(last_ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < last_ids.size(); i++)
      chk("order_id", 32'(last_ids[i]), 32'(i));
    chk("count4", 32'(gnt_count), 32'd4);
    for (int i = 0; i < 4; i++) chk("pop_once", 32'(popn[i]), 32'd1);
    repeat (3) cycle();

    // recall: only rsp eligible
    clear_all();
    for (int i = 0; i < 4; i++) qcnt[i] = 1;
    recall_pending = 1;
    repeat (2) cycle();
    chk("recall_rsp", 32'(popn[1]), 32'd1);
    repeat (5) cycle();
    chk("recall_idle", 32'(gnt_valid), 32'd0);
    recall_pending = 0;
    repeat (8) cycle();

    // starvation boost of req behind a refilled rsp
    clear_all();
    qcnt[2] = 4;
    for (int k = 0; k < 8; k++) begin
      if (qcnt[1] == 0) qcnt[1] = 1;
      cycle();
    end
    chk("boost_req_pop", 32'(popn[2]), 32'd1);
    chk("boost_4th", 32'(last_ids[3]), 32'd2);
    for (int k = 0; k < 8; k++) begin
      if (qcnt[1] == 0) qcnt[1] = 1;
      cycle();
    end
    chk("age_cleared", 32'(popn[2]), 32'd2);
    qcnt[1] = 0;
    repeat (4) cycle();

    // long hold with stall toggling
    clear_all();
    qcnt[2] = 1;
    qcnt[3] = 1;
    gnt_ready = 0;
    cycle();
    for (int k = 0; k < 10; k++) begin
      req_stall = k[0];
      cycle();
    end
    chk("hold_nopop", 32'(popn[2] + popn[3]), 32'd0);
    req_stall = 0;
    gnt_ready = 1;
    cycle();
    chk("hold_gap", 32'(gnt_valid), 32'd0);
    repeat (6) cycle();

    // dma_pending blocks rst_tb
    clear_all();
    qcnt[0] = 1;
    qcnt[3] = 1;
    dma_pending = 1;
    repeat (4) cycle();
    chk("dpend_dma", 32'(popn[3]), 32'd1);
    chk("dpend_norst", 32'(popn[0]), 32'd0);
    dma_pending = 0;
    repeat (3) cycle();
    chk("dpend_rst", 32'(popn[0]), 32'd1);

    // async reset in the middle of a hold
    clear_all();
    qcnt[2] = 1;
    gnt_ready = 0;
    repeat (3) cycle();
    gnt_ready = 1;
    rst = 0;
    #1;
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    chk("mid_rst_oh", 32'(gnt_onehot), 32'd0);
    chk("mid_rst_id", 32'(gnt_id), 32'd0);
    chk("mid_rst_boost", 32'(gnt_boost), 32'd0);
    chk("mid_rst_count", 32'(gnt_count), 32'd0);
    chk("mid_rst_pops",
        32'({pop_dma, pop_req, pop_rsp, pop_rst_tb}), 32'd0);
    model_reset();
    @(posedge clk); #3;
    rst = 1;
    #1;
    repeat (6) cycle();
    chk("post_rst_pop", 32'(popn[2]), 32'd1);

    // randomized traffic
    clear_all();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0 && qcnt[i] < 3) qcnt[i]++;
      recall_pending = ($urandom_range(7) == 0);
      req_stall      = ($urandom_range(3) == 0);
      dma_pending    = ($urandom_range(3) == 0);
      arb_en         = ($urandom_range(3) != 0);
      gnt_ready      = $urandom_range(1) == 1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
